// File: rtl/predictor_pkg.sv
// Shared widths and helper functions for the gshare direction predictor:
// counter reset value, saturating step and PHT index hash.
package predictor_pkg;

    localparam int DEF_INDEX_WIDTH = 6;
    localparam int DEF_HIST_WIDTH  = 4;
    localparam int DEF_CNT_WIDTH   = 2;
    localparam int MAX_CNT_WIDTH   = 4;
    localparam int MAX_IDX_WIDTH   = 16;

    // Weakly taken: only the MSB of a width-bit counter is set.
    function automatic logic [MAX_CNT_WIDTH-1:0] cnt_reset(input int width);
        return MAX_CNT_WIDTH'(4'd1 << (width - 1));
    endfunction

    function automatic logic [MAX_CNT_WIDTH-1:0] sat_next(
        input logic [MAX_CNT_WIDTH-1:0] cnt,
        input int                       width,
        input logic                     taken
    );
        logic [MAX_CNT_WIDTH-1:0] max_v;
        max_v = MAX_CNT_WIDTH'((5'd1 << width) - 5'd1);
        if (taken)
            return (cnt == max_v) ? cnt : cnt + 1'b1;
        else
            return (cnt == '0) ? cnt : cnt - 1'b1;
    endfunction

    // History sits in the low bits; callers zero-extend and truncate.
    function automatic logic [MAX_IDX_WIDTH-1:0] pht_index(
        input logic [MAX_IDX_WIDTH-1:0] addr,
        input logic [MAX_IDX_WIDTH-1:0] hist
    );
        return addr ^ hist;
    endfunction

endpackage

// File: rtl/gshare_predictor_if.sv
// Fetch-side query/prediction and resolve-side update signals of the
// gshare predictor; master is the pipeline, slave is the predictor.
interface gshare_predictor_if
    import predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int HIST_WIDTH  = DEF_HIST_WIDTH
);
    logic                   query_valid;
    logic [INDEX_WIDTH-1:0] query_addr;
    logic                   pred_valid;
    logic                   pred_taken;
    logic [HIST_WIDTH-1:0]  pred_hist;
    logic                   update_valid;
    logic [INDEX_WIDTH-1:0] update_addr;
    logic [HIST_WIDTH-1:0]  update_hist;
    logic                   update_taken;
    logic                   update_mispredict;

    modport master (
        output query_valid, query_addr,
        input  pred_valid, pred_taken, pred_hist,
        output update_valid, update_addr, update_hist, update_taken, update_mispredict
    );

    modport slave (
        input  query_valid, query_addr,
        output pred_valid, pred_taken, pred_hist,
        input  update_valid, update_addr, update_hist, update_taken, update_mispredict
    );
endinterface

// File: rtl/sat_counter_param.sv
// Width-generic saturating up/down counter, one per PHT entry; resets to
// weakly taken and steps only when enabled.
module sat_counter_param
    import predictor_pkg::*;
#(
    parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 taken_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i)
            cnt_d = CNT_WIDTH'(sat_next(MAX_CNT_WIDTH'(cnt_q), CNT_WIDTH, taken_i));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            cnt_q <= CNT_WIDTH'(cnt_reset(CNT_WIDTH));
        else
            cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor: PHT of saturating counters indexed by
// addr ^ speculative GHR, one-cycle registered prediction, mispredict recovery.
// Optional lookup/mispredict statistics under GSHARE_PREDICTOR_STATS_EN.
module gshare_predictor
    import predictor_pkg::*;
#(
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
    parameter int HIST_WIDTH  = DEF_HIST_WIDTH,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
`ifdef GSHARE_PREDICTOR_STATS_EN
    output logic [31:0] stat_lookups,
    output logic [31:0] stat_mispredicts,
`endif
    gshare_predictor_if.slave bus
);
    localparam int PHT_ENTRIES = 1 << INDEX_WIDTH;

    logic [CNT_WIDTH-1:0]   pht_cnt [PHT_ENTRIES];
    logic [INDEX_WIDTH-1:0] query_idx;
    logic [INDEX_WIDTH-1:0] update_idx;
    logic                   pred_bit;
    logic                   flush;
    logic                   accept;

    logic [HIST_WIDTH-1:0]  ghr_q,        ghr_d;
    logic                   pred_valid_q, pred_valid_d;
    logic                   pred_taken_q, pred_taken_d;
    logic [HIST_WIDTH-1:0]  pred_hist_q,  pred_hist_d;

    assign query_idx  = INDEX_WIDTH'(pht_index(MAX_IDX_WIDTH'(bus.query_addr),
                                               MAX_IDX_WIDTH'(ghr_q)));
    assign update_idx = INDEX_WIDTH'(pht_index(MAX_IDX_WIDTH'(bus.update_addr),
                                               MAX_IDX_WIDTH'(bus.update_hist)));

    // Read-before-write: the counter array output is the pre-update value.
    assign pred_bit = pht_cnt[query_idx][CNT_WIDTH-1];
    assign flush    = bus.update_valid & bus.update_mispredict;
    assign accept   = bus.query_valid & ~flush;

    for (genvar i = 0; i < PHT_ENTRIES; i++) begin : g_pht
        sat_counter_param #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
            .clk_i   (clk_in),
            .rst_i   (rst_in),
            .en_i    (rdy_in & bus.update_valid & (update_idx == INDEX_WIDTH'(i))),
            .taken_i (bus.update_taken),
            .cnt_o   (pht_cnt[i])
        );
    end

    always_comb begin
        ghr_d        = ghr_q;
        pred_valid_d = 1'b0;
        pred_taken_d = pred_taken_q;
        pred_hist_d  = pred_hist_q;
        if (accept) begin
            pred_valid_d = 1'b1;
            pred_taken_d = pred_bit;
            pred_hist_d  = ghr_q;
            // Truncating the concatenation also covers HIST_WIDTH == 1.
            ghr_d        = HIST_WIDTH'({ghr_q, pred_bit});
        end
        if (flush)
            ghr_d = HIST_WIDTH'({bus.update_hist, bus.update_taken});
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            ghr_q        <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
            pred_hist_q  <= '0;
        end else if (rdy_in) begin
            ghr_q        <= ghr_d;
            pred_valid_q <= pred_valid_d;
            pred_taken_q <= pred_taken_d;
            pred_hist_q  <= pred_hist_d;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_taken = pred_taken_q;
    assign bus.pred_hist  = pred_hist_q;

`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0] lookups_q, lookups_d;
    logic [31:0] mispredicts_q, mispredicts_d;

    always_comb begin
        lookups_d     = lookups_q;
        mispredicts_d = mispredicts_q;
        if (accept)
            lookups_d = lookups_q + 32'd1;
        if (flush)
            mispredicts_d = mispredicts_q + 32'd1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            lookups_q     <= '0;
            mispredicts_q <= '0;
        end else if (rdy_in) begin
            lookups_q     <= lookups_d;
            mispredicts_q <= mispredicts_d;
        end
    end

    assign stat_lookups     = lookups_q;
    assign stat_mispredicts = mispredicts_q;
`endif
endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor at default parameters; each vector
// compares {pred_valid, pred_taken, pred_hist} against hand-computed values.
module tb_gshare_predictor;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [5:0] obs;

    gshare_predictor_if #(.INDEX_WIDTH(6), .HIST_WIDTH(4)) bus ();

`ifdef GSHARE_PREDICTOR_STATS_EN
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;
`endif

    gshare_predictor #(.INDEX_WIDTH(6), .HIST_WIDTH(4), .CNT_WIDTH(2)) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .rdy_in           (rdy_in),
`ifdef GSHARE_PREDICTOR_STATS_EN
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts),
`endif
        .bus              (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
        obs = {bus.pred_valid, bus.pred_taken, bus.pred_hist};
    endtask

    task automatic idle();
        bus.query_valid       = 1'b0;
        bus.query_addr        = '0;
        bus.update_valid      = 1'b0;
        bus.update_addr       = '0;
        bus.update_hist       = '0;
        bus.update_taken      = 1'b0;
        bus.update_mispredict = 1'b0;
    endtask

    task automatic query(input logic [5:0] a);
        bus.query_valid = 1'b1;
        bus.query_addr  = a;
    endtask

    task automatic update(input logic [5:0] a, input logic [3:0] h,
                          input logic t, input logic m);
        bus.update_valid      = 1'b1;
        bus.update_addr       = a;
        bus.update_hist       = h;
        bus.update_taken      = t;
        bus.update_mispredict = m;
    endtask

    task automatic do_reset();
        idle();
        rdy_in = 1'b1;
        rst_in = 1'b1;
        tick();
        tick();
        rst_in = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (obs !== 6'b0_0_0000) begin
            miscompares++; $display("FAIL reset_outputs got %b want %b", obs, 6'b000000);
        end
        idle(); query(6'h05); tick();
        vectors++;
        if (obs !== 6'b1_1_0000) begin
            miscompares++; $display("FAIL reset_first_query got %b want %b", obs, 6'b110000);
        end
        // GHR is now 0001: idx = 0 ^ 1 = 1, weakly taken.
        idle(); query(6'h00); tick();
        vectors++;
        if (obs !== 6'b1_1_0001) begin
            miscompares++; $display("FAIL reset_ghr_shift got %b want %b", obs, 6'b110001);
        end
        idle(); tick();
        vectors++;
        if (obs !== 6'b0_1_0001) begin
            miscompares++; $display("FAIL idle_hold got %b want %b", obs, 6'b010001);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); update(6'h05, 4'h0, 1'b0, 1'b0); tick();
        end
        // Fourth decrement doubles as the history restore to 0000.
        idle(); update(6'h05, 4'h0, 1'b0, 1'b1); tick();
        vectors++;
        if (obs !== 6'b0_0_0000) begin
            miscompares++; $display("FAIL sat_restore_cycle got %b want %b", obs, 6'b000000);
        end
        idle(); query(6'h05); tick();
        vectors++;
        if (obs !== 6'b1_0_0000) begin
            miscompares++; $display("FAIL sat_low_query got %b want %b", obs, 6'b100000);
        end
        idle(); update(6'h05, 4'h0, 1'b1, 1'b0); tick();
        idle(); query(6'h05); tick();
        vectors++;
        if (obs !== 6'b1_0_0000) begin
            miscompares++; $display("FAIL sat_low_plus1 got %b want %b", obs, 6'b100000);
        end
        idle(); update(6'h05, 4'h0, 1'b1, 1'b0); tick();
        idle(); query(6'h05); tick();
        vectors++;
        if (obs !== 6'b1_1_0000) begin
            miscompares++; $display("FAIL sat_low_plus2 got %b want %b", obs, 6'b110000);
        end
        // GHR = 0001; two increments reach 11 and stay, one decrement -> 10.
        idle(); update(6'h05, 4'h0, 1'b1, 1'b0); tick();
        idle(); update(6'h05, 4'h0, 1'b1, 1'b0); tick();
        idle(); update(6'h05, 4'h0, 1'b0, 1'b0); tick();
        idle(); query(6'h04); tick();
        vectors++;
        if (obs !== 6'b1_1_0001) begin
            miscompares++; $display("FAIL sat_high_hold got %b want %b", obs, 6'b110001);
        end
    endtask

    task automatic test_recovery();
        logic [5:0] exp_q [3];
        exp_q = '{6'b1_1_0000, 6'b1_1_0001, 6'b1_1_0011};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle(); query(6'h00); tick();
            vectors++;
            if (obs !== exp_q[i]) begin
                miscompares++; $display("FAIL rec_query%0d got %b want %b", i, obs, exp_q[i]);
            end
        end
        idle(); query(6'h00); update(6'h00, 4'b0001, 1'b0, 1'b1); tick();
        vectors++;
        if (obs !== 6'b0_1_0011) begin
            miscompares++; $display("FAIL rec_flush_drop got %b want %b", obs, 6'b010011);
        end
        idle(); query(6'h00); tick();
        vectors++;
        if (obs !== 6'b1_1_0010) begin
            miscompares++; $display("FAIL rec_ghr_restored got %b want %b", obs, 6'b110010);
        end
        // Correct prediction: PHT[1] 01 -> 00, GHR stays 0101.
        idle(); update(6'h00, 4'b0001, 1'b0, 1'b0); tick();
        idle(); query(6'h04); tick();
        vectors++;
        if (obs !== 6'b1_0_0101) begin
            miscompares++; $display("FAIL rec_correct_update got %b want %b", obs, 6'b100101);
        end
        idle(); query(6'h00); bus.update_mispredict = 1'b1; tick();
        vectors++;
        if (obs !== 6'b1_1_1010) begin
            miscompares++; $display("FAIL rec_stray_mispredict got %b want %b", obs, 6'b111010);
        end
        idle(); query(6'h00); tick();
        vectors++;
        if (obs !== 6'b1_1_0101) begin
            miscompares++; $display("FAIL rec_stray_ghr got %b want %b", obs, 6'b110101);
        end
    endtask

    task automatic test_collision();
        do_reset();
        idle(); query(6'h05); update(6'h05, 4'h0, 1'b0, 1'b0); tick();
        vectors++;
        if (obs !== 6'b1_1_0000) begin
            miscompares++; $display("FAIL coll_old_value got %b want %b", obs, 6'b110000);
        end
        idle(); query(6'h04); tick();
        vectors++;
        if (obs !== 6'b1_0_0001) begin
            miscompares++; $display("FAIL coll_new_value got %b want %b", obs, 6'b100001);
        end
    endtask

    task automatic test_stall();
        do_reset();
        idle(); query(6'h05); tick();
        idle(); query(6'h04); update(6'h04, 4'b0001, 1'b0, 1'b1);
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (obs !== 6'b1_1_0000) begin
                miscompares++; $display("FAIL stall_hold%0d got %b want %b", i, obs, 6'b110000);
            end
        end
        rdy_in = 1'b1;
        idle(); query(6'h04); tick();
        vectors++;
        if (obs !== 6'b1_1_0001) begin
            miscompares++; $display("FAIL stall_resume got %b want %b", obs, 6'b110001);
        end
        idle(); rdy_in = 1'b0; rst_in = 1'b1; tick();
        vectors++;
        if (obs !== 6'b0_0_0000) begin
            miscompares++; $display("FAIL reset_over_stall got %b want %b", obs, 6'b000000);
        end
        rst_in = 1'b0; rdy_in = 1'b1;
    endtask

`ifdef GSHARE_PREDICTOR_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(); query(6'h00); tick();
        end
        for (int i = 0; i < 2; i++) begin
            idle(); update(6'h00, 4'h0, 1'b1, 1'b1); tick();
        end
        idle(); query(6'h00); update(6'h00, 4'h0, 1'b1, 1'b1); rdy_in = 1'b0; tick();
        rdy_in = 1'b1; idle();
        vectors++;
        if ({stat_lookups, stat_mispredicts} !== {32'd5, 32'd2}) begin
            miscompares++;
            $display("FAIL stats_count got %0d/%0d want 5/2", stat_lookups, stat_mispredicts);
        end
        rst_in = 1'b1; tick(); rst_in = 1'b0;
        vectors++;
        if ({stat_lookups, stat_mispredicts} !== 64'd0) begin
            miscompares++;
            $display("FAIL stats_reset got %0d/%0d want 0/0", stat_lookups, stat_mispredicts);
        end
    endtask
`endif

    initial begin
        idle();
        rst_in = 1'b1;
        rdy_in = 1'b1;
        test_reset();
        test_saturation();
        test_recovery();
        test_collision();
        test_stall();
`ifdef GSHARE_PREDICTOR_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
